sr_input_conditioner: RTL and testbench
=======================================

SR_INPUT_CONDITIONER -- requirements
Module: sr_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_N, default 4: consecutive stable synchronized cycles required before a button level is accepted; legal range 1..255.
REQ-002 Parameter PULSE_N, default 2: number of cycles S/R and C are driven per command; legal range 1..255.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port btn_s, input, 1 bit: raw asynchronous set button, active-high.
REQ-006 Port btn_r, input, 1 bit: raw asynchronous reset button, active-high.
REQ-007 Port S, output, 1 bit: set drive to the downstream enabled SR latch.
REQ-008 Port R, output, 1 bit: reset drive to the downstream enabled SR latch.
REQ-009 Port C, output, 1 bit: latch enable.
REQ-010 Port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-011 Port conflict, output, 1 bit: one-cycle pulse when set and reset requests occur in the same cycle.
REQ-012 Port dropped, output, 1 bit: one-cycle pulse when a request is discarded because the pending slot is full.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer with reset value 0.
REQ-014 Each synchronized button SHALL have a debounced level, reset 0, which flips only after the synchronized value has differed from it for DEBOUNCE_N consecutive cycles; any cycle of agreement clears the count.
REQ-015 A request SHALL be a debounced 0->1 transition, detected against a registered copy of the debounced level; 1->0 transitions generate no request.
REQ-016 Latency: with a raw button rising before edge 0 and held, S (or R) and C SHALL be high after edge DEBOUNCE_N+2.
REQ-017 FSM states: IDLE, DRIVE, GAP; all of S, R, C, busy SHALL be registered outputs.
REQ-018 IDLE: on a request (or a non-empty pending slot, which has priority), go to DRIVE with C=1 and exactly one of S or R =1 per command type; the pending slot is consumed.
REQ-019 DRIVE SHALL last exactly PULSE_N cycles, then go to GAP with S=R=C=0.
REQ-020 GAP SHALL last exactly 1 cycle (latch memory state), then return to IDLE.
REQ-021 A request arriving in DRIVE or GAP SHALL be stored in the single pending slot if empty; otherwise it SHALL be discarded and dropped SHALL pulse for 1 cycle.
REQ-022 Simultaneous set and reset requests in the same cycle SHALL both be discarded, with conflict pulsing for 1 cycle and the FSM and pending slot unaffected.
REQ-023 S=R=1 SHALL never be driven in any cycle.
REQ-024 C SHALL be 0 whenever S=R=0.

Reset
REQ-025 While rst_n=0: S, R, C, busy, conflict, dropped=0; synchronizers, debounced levels, counters=0; pending slot empty; FSM in IDLE.
REQ-026 Assertion of rst_n mid-DRIVE SHALL force all outputs to 0 immediately, without waiting for a clock edge.
REQ-027 After release of rst_n, a button already held high SHALL produce exactly one request, once it has been debounced.

Verification
REQ-028 Defaults; btn_s rises before edge 0 and is held -> S=1, C=1 after edges 6 and 7; S=C=0 after edge 8; busy=0 after edge 9.
REQ-029 btn_r glitches high for 3 cycles with DEBOUNCE_N=4 -> no R, C, or busy activity.
REQ-030 btn_s and btn_r rise in the same cycle and are held -> conflict pulses once; S, R, C remain 0.
REQ-031 btn_s request, then btn_r request during DRIVE, then btn_s request during that DRIVE -> S pulse, GAP, R pulse; dropped pulses once for the third request.
REQ-032 rst_n driven low mid-DRIVE -> S, C go to 0 asynchronously; after release with buttons low, the block stays idle.

Source files
------------

// File: rtl/sr_input_conditioner_if.sv
// Button inputs and latch drive outputs of sr_input_conditioner.
interface sr_input_conditioner_if;
    logic btn_s;
    logic btn_r;
    logic S;
    logic R;
    logic C;
    logic busy;
    logic conflict;
    logic dropped;

    modport master (
        output btn_s, btn_r,
        input  S, R, C, busy, conflict, dropped
    );

    modport slave (
        input  btn_s, btn_r,
        output S, R, C, busy, conflict, dropped
    );
endinterface

// File: rtl/sr_input_conditioner.sv
// Synchronizes and debounces set/reset buttons, then sequences fixed-length
// S/R + C command pulses to a downstream enabled SR latch.
module sr_input_conditioner #(
    parameter int unsigned DEBOUNCE_N = 4,
    parameter int unsigned PULSE_N    = 2
) (
    input logic                    clk,
    input logic                    rst_n,
    sr_input_conditioner_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

    localparam logic [7:0] CNT_LAST  = 8'(DEBOUNCE_N - 1);
    localparam logic [7:0] PCNT_LAST = 8'(PULSE_N - 1);

    // Index 0 = set button, index 1 = reset button
    logic [1:0] w_raw;
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_deb;
    logic [1:0] r_deb_q;
    logic [7:0] r_cnt [2];

    logic [1:0] w_req;
    logic       w_conflict;
    logic       w_new;
    logic       w_new_r;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_pcnt;
    logic [7:0] w_pcnt_nxt;
    logic       r_pend_v;
    logic       w_pend_v_nxt;
    logic       r_pend_r;
    logic       w_pend_r_nxt;
    logic       r_s, r_r, r_c, r_busy, r_conflict, r_dropped;
    logic       w_s_nxt, w_r_nxt, w_c_nxt, w_busy_nxt, w_dropped_nxt;
    logic       w_start;
    logic       w_start_r;

    assign w_raw = {bus.btn_r, bus.btn_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_q <= '0;
            for (int unsigned i = 0; i < 2; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_deb_q <= r_deb;
            for (int unsigned i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_cnt[i] <= '0;
                    r_deb[i] <= ~r_deb[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign w_req      = r_deb & ~r_deb_q;
    assign w_conflict = &w_req;
    assign w_new      = ^w_req;
    assign w_new_r    = w_req[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pcnt     <= '0;
            r_pend_v   <= 1'b0;
            r_pend_r   <= 1'b0;
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_c        <= 1'b0;
            r_busy     <= 1'b0;
            r_conflict <= 1'b0;
            r_dropped  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pcnt     <= w_pcnt_nxt;
            r_pend_v   <= w_pend_v_nxt;
            r_pend_r   <= w_pend_r_nxt;
            r_s        <= w_s_nxt;
            r_r        <= w_r_nxt;
            r_c        <= w_c_nxt;
            r_busy     <= w_busy_nxt;
            r_conflict <= w_conflict;
            r_dropped  <= w_dropped_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pcnt_nxt    = r_pcnt;
        w_pend_v_nxt  = r_pend_v;
        w_pend_r_nxt  = r_pend_r;
        w_s_nxt       = r_s;
        w_r_nxt       = r_r;
        w_c_nxt       = r_c;
        w_dropped_nxt = 1'b0;
        w_start       = 1'b0;
        w_start_r     = 1'b0;

        unique case (r_state)
            IDLE: begin
                // Pending slot is served first; a same-cycle request refills it
                if (r_pend_v) begin
                    w_start      = 1'b1;
                    w_start_r    = r_pend_r;
                    w_pend_v_nxt = w_new;
                    w_pend_r_nxt = w_new_r;
                end else if (w_new) begin
                    w_start   = 1'b1;
                    w_start_r = w_new_r;
                end
            end
            DRIVE: begin
                if (r_pcnt == PCNT_LAST) begin
                    w_state_nxt = GAP;
                    w_s_nxt     = 1'b0;
                    w_r_nxt     = 1'b0;
                    w_c_nxt     = 1'b0;
                end else begin
                    w_pcnt_nxt = r_pcnt + 8'd1;
                end
            end
            GAP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_s_nxt     = 1'b0;
                w_r_nxt     = 1'b0;
                w_c_nxt     = 1'b0;
            end
        endcase

        if (r_state != IDLE && w_new) begin
            if (!r_pend_v) begin
                w_pend_v_nxt = 1'b1;
                w_pend_r_nxt = w_new_r;
            end else begin
                w_dropped_nxt = 1'b1;
            end
        end

        if (w_start) begin
            w_state_nxt = DRIVE;
            w_pcnt_nxt  = '0;
            w_s_nxt     = ~w_start_r;
            w_r_nxt     = w_start_r;
            w_c_nxt     = 1'b1;
        end

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    assign bus.S        = r_s;
    assign bus.R        = r_r;
    assign bus.C        = r_c;
    assign bus.busy     = r_busy;
    assign bus.conflict = r_conflict;
    assign bus.dropped  = r_dropped;

endmodule

// File: tb/tb_sr_input_conditioner.sv
// Bench for sr_input_conditioner: a default-parameter instance and a long-pulse
// instance share the buttons and are checked each cycle against a command-level model.
module tb_sr_input_conditioner;

    localparam int DB = 4;
    localparam int PA = 2;
    localparam int PL = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic tb_btn_s = 1'b0;
    logic tb_btn_r = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    sr_input_conditioner_if if_a ();
    sr_input_conditioner_if if_l ();

    assign if_a.btn_s = tb_btn_s;
    assign if_a.btn_r = tb_btn_r;
    assign if_l.btn_s = tb_btn_s;
    assign if_l.btn_r = tb_btn_r;

    sr_input_conditioner u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    sr_input_conditioner #(.DEBOUNCE_N(DB), .PULSE_N(PL)) u_dut_l (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_l)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Model: raw -> 2-stage sync -> level accepted once the last DB samples all
    // disagree with it; rising levels become commands on a DRIVE/GAP timeline.
    bit        m_s1s, m_s2s, m_s1r, m_s2r;
    bit [7:0]  m_hist_s, m_hist_r;
    bit        m_deb_s, m_deb_r, m_req_s, m_req_r;
    int        m_dl [2];
    int        m_gl [2];
    bit        m_typ [2];
    bit        m_pv [2];
    bit        m_pt [2];
    bit        m_conf [2];
    bit        m_drop [2];
    int        m_plen [2] = '{PA, PL};

    task automatic model_reset();
        m_s1s = 0; m_s2s = 0; m_s1r = 0; m_s2r = 0;
        m_hist_s = '0; m_hist_r = '0;
        m_deb_s = 0; m_deb_r = 0; m_req_s = 0; m_req_r = 0;
        for (int i = 0; i < 2; i++) begin
            m_dl[i] = 0; m_gl[i] = 0; m_typ[i] = 0; m_pv[i] = 0;
            m_pt[i] = 0; m_conf[i] = 0; m_drop[i] = 0;
        end
    endtask

    function automatic bit all_differ(input bit [7:0] h, input bit lvl);
        for (int k = 0; k < DB; k++) if (h[k] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        bit newreq, newt, old;
        newreq = m_req_s ^ m_req_r;
        newt   = m_req_r;
        for (int i = 0; i < 2; i++) begin
            m_conf[i] = m_req_s && m_req_r;
            m_drop[i] = 0;
            if (m_dl[i] == 0 && m_gl[i] == 0) begin
                if (m_pv[i]) begin
                    m_dl[i] = m_plen[i]; m_typ[i] = m_pt[i];
                    m_pv[i] = newreq; m_pt[i] = newt;
                end else if (newreq) begin
                    m_dl[i] = m_plen[i]; m_typ[i] = newt;
                end
            end else begin
                if (m_dl[i] > 0) begin
                    m_dl[i]--;
                    if (m_dl[i] == 0) m_gl[i] = 1;
                end else begin
                    m_gl[i] = 0;
                end
                if (newreq) begin
                    if (!m_pv[i]) begin m_pv[i] = 1; m_pt[i] = newt; end
                    else m_drop[i] = 1;
                end
            end
        end
        old = m_deb_s;
        m_hist_s = {m_hist_s[6:0], m_s2s};
        if (all_differ(m_hist_s, m_deb_s)) m_deb_s = ~m_deb_s;
        m_req_s = m_deb_s & ~old;
        old = m_deb_r;
        m_hist_r = {m_hist_r[6:0], m_s2r};
        if (all_differ(m_hist_r, m_deb_r)) m_deb_r = ~m_deb_r;
        m_req_r = m_deb_r & ~old;
        m_s2s = m_s1s; m_s1s = tb_btn_s;
        m_s2r = m_s1r; m_s1r = tb_btn_r;
    endtask

    function automatic logic [5:0] mexp(input int i);
        return {m_dl[i] > 0 && !m_typ[i], m_dl[i] > 0 && m_typ[i], m_dl[i] > 0,
                (m_dl[i] > 0) || (m_gl[i] > 0), m_conf[i], m_drop[i]};
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    logic [5:0] act_a, act_l;
    assign act_a = {if_a.S, if_a.R, if_a.C, if_a.busy, if_a.conflict, if_a.dropped};
    assign act_l = {if_l.S, if_l.R, if_l.C, if_l.busy, if_l.conflict, if_l.dropped};

    initial begin
        forever begin
            @(negedge clk);
            check("model dut_a {S,R,C,busy,conflict,dropped}", 32'(act_a), 32'(mexp(0)));
            check("model dut_l {S,R,C,busy,conflict,dropped}", 32'(act_l), 32'(mexp(1)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_wait(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    int cnt_a, cnt_b, cnt_c, cnt_d;
    bit seen;

    initial begin
        #1 rst_n = 1'b0;
        idle_wait(3);
        check("reset outputs dut_a", 32'(act_a), 32'd0);
        check("reset outputs dut_l", 32'(act_l), 32'd0);
        rst_n = 1'b1;
        idle_wait(2);

        // Held btn_s: command after edge DB+2
        tb_btn_s = 1'b1;
        idle_wait(6);
        check("latency S before edge 6", 32'(if_a.S), 32'd0);
        tick();
        check("latency S,C after edge 6", 32'({if_a.S, if_a.C}), 32'b11);
        tick();
        check("S,C after edge 7", 32'({if_a.S, if_a.C}), 32'b11);
        tick();
        check("S,C,busy after edge 8", 32'({if_a.S, if_a.C, if_a.busy}), 32'b001);
        tick();
        check("busy after edge 9", 32'(if_a.busy), 32'd0);
        idle_wait(30);
        tb_btn_s = 1'b0;
        idle_wait(20);

        // Three-cycle glitch on btn_r is filtered
        tb_btn_r = 1'b1;
        idle_wait(3);
        tb_btn_r = 1'b0;
        cnt_a = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (if_a.R || if_a.C || if_a.busy) cnt_a++;
        end
        check("glitch activity cycles", 32'(cnt_a), 32'd0);

        // Simultaneous presses
        tb_btn_s = 1'b1;
        tb_btn_r = 1'b1;
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (if_a.conflict) cnt_a++;
            if (if_a.S || if_a.R || if_a.C) cnt_b++;
        end
        check("conflict pulses", 32'(cnt_a), 32'd1);
        check("conflict drive cycles", 32'(cnt_b), 32'd0);
        tb_btn_s = 1'b0;
        tb_btn_r = 1'b0;
        idle_wait(20);

        // Set, then reset pending, then a third request dropped (long-pulse instance)
        tb_btn_s = 1'b1;
        cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
        for (int k = 0; k < 80; k++) begin
            if (k == 7)  tb_btn_s = 1'b0;
            if (k == 8)  tb_btn_r = 1'b1;
            if (k == 13) tb_btn_s = 1'b1;
            tick();
            if (if_l.S) cnt_a++;
            if (if_l.R) cnt_b++;
            if (if_l.dropped) cnt_c++;
            if (if_l.S && if_l.R) cnt_d++;
        end
        check("pending S cycles", 32'(cnt_a), 32'(PL));
        check("pending R cycles", 32'(cnt_b), 32'(PL));
        check("dropped pulses", 32'(cnt_c), 32'd1);
        check("S and R together", 32'(cnt_d), 32'd0);
        tb_btn_s = 1'b0;
        tb_btn_r = 1'b0;
        idle_wait(40);

        // Asynchronous reset mid-DRIVE
        tb_btn_s = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            seen = if_a.S;
        end
        check("S reached before async reset", 32'({if_a.S, if_a.C}), 32'b11);
        #1 rst_n = 1'b0;
        #1;
        check("async reset dut_a", 32'(act_a), 32'd0);
        check("async reset dut_l", 32'(act_l), 32'd0);
        tb_btn_s = 1'b0;
        idle_wait(3);
        rst_n = 1'b1;
        cnt_a = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (if_a.busy || if_l.busy) cnt_a++;
        end
        check("idle after reset release", 32'(cnt_a), 32'd0);

        // Button held across reset release yields exactly one command
        rst_n = 1'b0;
        tb_btn_r = 1'b1;
        idle_wait(2);
        rst_n = 1'b1;
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (if_a.R) cnt_a++;
            if (if_l.R) cnt_b++;
        end
        check("held-through-reset R cycles dut_a", 32'(cnt_a), 32'(PA));
        check("held-through-reset R cycles dut_l", 32'(cnt_b), 32'(PL));
        tb_btn_r = 1'b0;
        idle_wait(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
